data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store path and the image-loader DMA that streams fingerprint pixels into memory. It grants at most one access per cycle and drives the memory's address, write-data, write-enable and output-enable lines from the winner. It returns a registered acknowledge with read data one cycle later. Arbitration is round-robin, plus a bounded DMA burst lock so image loads run back-to-back without starving the CPU.

## Interface
Parameters:
- ADDR_W, 32, address width passed through to memory
- DATA_W, 32, data width
- MAX_BURST, 8, max consecutive locked DMA grants while CPU waits (range 1..255)

Ports:
- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  combinational; access accepted this cycle
- cpu_ack  out  1  registered; one-cycle pulse the cycle after cpu_gnt
- cpu_rdata  out  DATA_W  registered read data, valid with cpu_ack on a read
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_ack, dma_rdata: same meanings as the cpu_* ports, for the DMA
- dma_lock  in  1  DMA requests burst ownership, sampled with dma_req
- mem_adr  out  ADDR_W  to memory address
- mem_wd  out  DATA_W  to memory write data
- mem_we  out  1  to memory write enable
- mem_oe  out  1  to memory output enable
- mem_rd  in  DATA_W  combinational memory read data
- burst_active  out  1  registered; DMA currently holds the burst lock

## Operation
- One access per cycle. Winner chosen combinationally from the requests and the state. The winner's gnt goes high and its addr/wdata/we drive mem_*.
- mem_we = winner_we, mem_oe = winner read. With no grant: mem_we = 0, mem_oe = 0, mem_adr = 0, mem_wd = 0.
- Write commits at the clock edge closing the grant cycle.
- On a read, mem_rd is captured into the winner's rdata register at the same edge. On a write the rdata register holds its old value.
- The requester may change or drop req and payload after the cycle its gnt is high.
- States: RR_CPU (CPU has priority on conflict), RR_DMA (DMA has priority on conflict), BURST (DMA locked). Counter burst_cnt is 8 bits.
- RR_CPU / RR_DMA:
  - Single requester wins regardless of state.
  - On a conflict, the priority side wins.
  - After any CPU grant, next state is RR_DMA.
  - After a DMA grant with dma_lock = 0, next state is RR_CPU.
  - After a DMA grant with dma_lock = 1, next state is BURST and burst_cnt = 1.
- BURST:
  - DMA wins on conflict while burst_cnt < MAX_BURST; each DMA grant increments burst_cnt.
  - When burst_cnt = MAX_BURST and cpu_req = 1, the CPU wins one grant, then state is BURST with burst_cnt = 0.
  - If dma_req = 0 or dma_lock = 0 in a cycle: exit to RR_CPU. The CPU is granted that cycle if it requests.
  - CPU requests while DMA is idle are not possible inside BURST, because exit happens first.
- Address and data pass through unmodified. Memory decoding is the memory's responsibility.

## Timing
- Reset values: all gnt, ack, mem_we, mem_oe and burst_active are 0. cpu_rdata, dma_rdata, mem_adr, mem_wd are 0. State is RR_CPU, burst_cnt = 0.
- While rst = 1, gnt, mem_we and mem_oe are forced to 0, so no memory write occurs in a reset cycle.
- An ack already scheduled from the cycle before reset is cleared.
- Latency: gnt in cycle N, ack and rdata in cycle N+1. Throughput is one access per cycle, sustained, for either port.
- Back-to-back grants to the same port give continuous ack pulses. Each ack corresponds to the grant one cycle earlier.
- burst_active is 1 in exactly the cycles where state = BURST.
- A read immediately after a write to the same address, in consecutive cycles, returns the new data.

## Test plan
- Reset, then idle: all outputs 0 and mem_we/mem_oe 0 for 5 cycles. Assert rst during a grant cycle: no write lands and no ack follows.
- CPU alone: write 0xDEADBEEF to address 0x04, then read 0x04. Expect cpu_gnt in cycles 1 and 2, cpu_ack in cycles 2 and 3, and cpu_rdata = 0xDEADBEEF in cycle 3.
- Conflict, no lock: both request reads for 6 cycles. Expect grants alternating CPU, DMA, CPU, … and each ack one cycle after its grant.
- Burst with MAX_BURST = 4: DMA locked writes to 0x00..0x09 while the CPU requests continuously. Expect 4 DMA grants, then 1 CPU grant, then 4 DMA, and so on. burst_active stays high throughout, and memory holds every DMA word.
- Burst exit: drop dma_lock mid-burst while the CPU requests. The CPU is granted the same cycle, state returns to round-robin, and burst_active falls on the next cycle.
- Write-then-read across ports: DMA writes 0x12345678 to 0x08, then the CPU reads 0x08 the next cycle. cpu_rdata = 0x12345678.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU
// load/store path and the image-loader DMA. Round-robin arbitration with a
// bounded DMA burst lock; one access per cycle, registered ack/rdata.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request channel
//   cpu_gnt (comb), cpu_ack, cpu_rdata (registered)
//   dma_req/we/addr/wdata/lock, dma_gnt (comb), dma_ack, dma_rdata
//   mem_adr/wd/we/oe          memory drive (combinational from the winner)
//   mem_rd                    memory read data (combinational)
//   burst_active              registered, high while DMA holds the burst lock
module data_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  output logic              mem_oe,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              burst_active
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    RR_CPU = 2'd0,
    RR_DMA = 2'd1,
    BURST  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]  dma_rdata_q, dma_rdata_d;
  logic               burst_active_q, burst_active_d;
  logic               cpu_win, dma_win;

  // Winner selection and next-state logic.
  always_comb begin
    cpu_win     = 1'b0;
    dma_win     = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;

    case (state_q)
      BURST: begin
        if (!dma_req || !dma_lock) begin
          // Lock released: leave burst, CPU gets this cycle if it asks.
          state_d     = RR_CPU;
          burst_cnt_d = '0;
          if (cpu_req)      cpu_win = 1'b1;
          else if (dma_req) dma_win = 1'b1;
        end else if (burst_cnt_q >= MAX_CNT && cpu_req) begin
          // Burst budget spent: CPU takes one slot, burst restarts.
          cpu_win     = 1'b1;
          burst_cnt_d = '0;
        end else begin
          dma_win = 1'b1;
          // Saturate so a CPU arriving late still wins immediately.
          if (burst_cnt_q < MAX_CNT) burst_cnt_d = CNT_W'(burst_cnt_q + 1'b1);
        end
      end
      default: begin
        if (cpu_req && dma_req) begin
          if (state_q == RR_DMA) dma_win = 1'b1;
          else                   cpu_win = 1'b1;
        end else if (cpu_req) begin
          cpu_win = 1'b1;
        end else if (dma_req) begin
          dma_win = 1'b1;
        end

        if (cpu_win) begin
          state_d = RR_DMA;
        end else if (dma_win) begin
          if (dma_lock) begin
            state_d     = BURST;
            burst_cnt_d = CNT_W'(1);
          end else begin
            state_d = RR_CPU;
          end
        end
      end
    endcase

    // No access may reach the memory while in reset.
    if (rst) begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
    end
  end

  // Memory drive and registered response next-values.
  always_comb begin
    mem_adr = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    mem_oe  = 1'b0;
    if (cpu_win) begin
      mem_adr = cpu_addr;
      mem_wd  = cpu_wdata;
      mem_we  = cpu_we;
      mem_oe  = !cpu_we;
    end else if (dma_win) begin
      mem_adr = dma_addr;
      mem_wd  = dma_wdata;
      mem_we  = dma_we;
      mem_oe  = !dma_we;
    end

    cpu_ack_d      = cpu_win;
    dma_ack_d      = dma_win;
    cpu_rdata_d    = cpu_rdata_q;
    dma_rdata_d    = dma_rdata_q;
    if (cpu_win && !cpu_we) cpu_rdata_d = mem_rd;
    if (dma_win && !dma_we) dma_rdata_d = mem_rd;
    burst_active_d = (state_d == BURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RR_CPU;
      burst_cnt_q    <= '0;
      cpu_ack_q      <= 1'b0;
      dma_ack_q      <= 1'b0;
      cpu_rdata_q    <= '0;
      dma_rdata_q    <= '0;
      burst_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      cpu_ack_q      <= cpu_ack_d;
      dma_ack_q      <= dma_ack_d;
      cpu_rdata_q    <= cpu_rdata_d;
      dma_rdata_q    <= dma_rdata_d;
      burst_active_q <= burst_active_d;
    end
  end

  assign cpu_gnt      = cpu_win;
  assign dma_gnt      = dma_win;
  assign cpu_ack      = cpu_ack_q;
  assign dma_ack      = dma_ack_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign dma_rdata    = dma_rdata_q;
  assign burst_active = burst_active_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter (MAX_BURST = 4). Directed stimulus; grants
// and memory drive are checked in the grant cycle, acks/rdata are checked by
// a separate monitor that pops expected responses from per-port queues.
module tb_data_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_lock, dma_gnt, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          mem_we, mem_oe, burst_active;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rd(mem_rd), .burst_active(burst_active)
  );

  // Small word-indexed memory model: combinational read, write at the edge.
  logic [DW-1:0] tb_mem [256];
  always @(posedge clk) if (mem_we) tb_mem[mem_adr[7:0]] <= mem_wd;
  assign mem_rd = tb_mem[mem_adr[7:0]];

  typedef struct {
    logic          rd;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          cpu_q[$];
  exp_t          dma_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [DW-1:0] last_c  = '0;
  logic [DW-1:0] last_d  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: each ack must match the oldest outstanding grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (cpu_ack === 1'b1) begin
        if (cpu_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cpu_ack_unexpected: got ack=1 expected ack=0 (cycle %0d)", cyc);
        end else begin
          e = cpu_q.pop_front();
          if (e.rd) last_c = e.data;
          chk("cpu_ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("cpu_rdata", cpu_rdata, last_c);
        end
      end
      if (dma_ack === 1'b1) begin
        if (dma_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL dma_ack_unexpected: got ack=1 expected ack=0 (cycle %0d)", cyc);
        end else begin
          e = dma_q.pop_front();
          if (e.rd) last_d = e.data;
          chk("dma_ack_cycle", 32'(cyc), 32'(e.cyc));
          chk("dma_rdata", dma_rdata, last_d);
        end
      end
    end
  end

  task automatic drive_cpu(input logic rq, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_dma(input logic rq, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma_req = rq; dma_we = we; dma_lock = lk; dma_addr = a; dma_wdata = d;
  endtask

  // Checks one cycle's grants and memory drive, queues the expected ack,
  // then advances to the next negedge.
  task automatic expect_cycle(input logic ec, input logic ed,
                              input logic [DW-1:0] crd, input logic [DW-1:0] drd,
                              input int eb, input string tag);
    exp_t          e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewe, eoe;
    #1;
    chk({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'(ec));
    chk({tag, " dma_gnt"}, 32'(dma_gnt), 32'(ed));
    if (eb >= 0) chk({tag, " burst_active"}, 32'(burst_active), 32'(eb));
    ea = '0; ew = '0; ewe = 1'b0; eoe = 1'b0;
    if (ec) begin
      ea = cpu_addr; ew = cpu_wdata; ewe = cpu_we; eoe = !cpu_we;
    end else if (ed) begin
      ea = dma_addr; ew = dma_wdata; ewe = dma_we; eoe = !dma_we;
    end
    chk({tag, " mem_adr"}, mem_adr, ea);
    chk({tag, " mem_wd"}, mem_wd, ew);
    chk({tag, " mem_we"}, 32'(mem_we), 32'(ewe));
    chk({tag, " mem_oe"}, 32'(mem_oe), 32'(eoe));
    if (ec) begin
      e.rd = !cpu_we; e.data = crd; e.cyc = cyc + 1;
      cpu_q.push_back(e);
    end
    if (ed) begin
      e.rd = !dma_we; e.data = drd; e.cyc = cyc + 1;
      dma_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Winner per burst cycle: 1 = CPU, 0 = DMA (MAX_BURST = 4).
  logic burst_pat [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};

  initial begin
    int            di;
    logic [AW-1:0] ca;
    logic          lk;
    for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    rst = 1'b1;
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, 0, '0, '0);
    repeat (3) @(negedge clk);

    // Reset with a pending CPU write: nothing granted, nothing written.
    drive_cpu(1, 1, 32'h20, 32'hFFFF_0000);
    expect_cycle(0, 0, '0, '0, 0, "reset_req");
    rst = 1'b0;
    drive_cpu(0, 0, '0, '0);
    chk("reset cpu_rdata", cpu_rdata, '0);
    chk("reset dma_rdata", dma_rdata, '0);
    for (int i = 0; i < 5; i++) expect_cycle(0, 0, '0, '0, 0, "idle");
    chk("reset no write", tb_mem[8'h20], '0);

    // CPU alone: write then read the same address in consecutive cycles.
    drive_cpu(1, 1, 32'h04, 32'hDEAD_BEEF);
    expect_cycle(1, 0, '0, '0, 0, "cpu_wr");
    drive_cpu(1, 0, 32'h04, '0);
    expect_cycle(1, 0, 32'hDEAD_BEEF, '0, 0, "cpu_rd");

    // DMA alone read returns the state to CPU priority.
    drive_cpu(0, 0, '0, '0);
    drive_dma(1, 0, 0, 32'h04, '0);
    expect_cycle(0, 1, '0, 32'hDEAD_BEEF, 0, "dma_rd");

    // Conflict without lock: strict alternation starting with the CPU.
    drive_cpu(1, 0, 32'h04, '0);
    drive_dma(1, 0, 0, 32'h00, '0);
    for (int i = 0; i < 6; i++)
      expect_cycle((i % 2) == 0, (i % 2) == 1, 32'hDEAD_BEEF, 32'h0, 0, "rr_conflict");

    // DMA write followed by CPU read of the same word.
    drive_cpu(0, 0, '0, '0);
    drive_dma(1, 1, 0, 32'h08, 32'h1234_5678);
    expect_cycle(0, 1, '0, '0, 0, "xport_wr");
    drive_dma(0, 0, 0, '0, '0);
    drive_cpu(1, 0, 32'h08, '0);
    expect_cycle(1, 0, 32'h1234_5678, '0, 0, "xport_rd");

    // Locked DMA burst against a continuously requesting CPU, then lock drop.
    di = 0;
    for (int k = 0; k < 13; k++) begin
      ca = (k <= 4) ? 32'h03 : ((k <= 9) ? 32'h07 : 32'h09);
      lk = (k < 12);
      drive_cpu(1, 0, ca, '0);
      drive_dma(1, 1, lk, 32'(di), 32'hA000_0000 | 32'(di));
      expect_cycle(burst_pat[k], !burst_pat[k], 32'hA000_0000 | ca, '0,
                   (k == 0) ? 0 : 1, "burst");
      if (!burst_pat[k]) di++;
    end
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, 0, '0, '0);
    expect_cycle(0, 0, '0, '0, 0, "burst_exit");
    for (int i = 0; i < 10; i++)
      chk("burst mem word", tb_mem[i], 32'hA000_0000 | 32'(i));
    chk("burst no stray write", tb_mem[8'h0A], '0);

    // Reset during a grant cycle: no write lands, no ack follows.
    drive_cpu(1, 1, 32'h30, 32'h5555_AAAA);
    expect_cycle(1, 0, '0, '0, 0, "pre_rst_wr");
    rst = 1'b1;
    drive_cpu(1, 1, 32'h31, 32'h0000_0BAD);
    drive_dma(1, 1, 0, 32'h32, 32'h0000_0BEE);
    expect_cycle(0, 0, '0, '0, 0, "rst_grant");
    rst = 1'b0;
    last_c = '0;
    last_d = '0;
    drive_cpu(0, 0, '0, '0);
    drive_dma(0, 0, 0, '0, '0);
    expect_cycle(0, 0, '0, '0, 0, "post_rst");
    chk("rst cpu_rdata cleared", cpu_rdata, '0);
    chk("write before rst", tb_mem[8'h30], 32'h5555_AAAA);
    chk("cpu write in rst", tb_mem[8'h31], '0);
    chk("dma write in rst", tb_mem[8'h32], '0);

    expect_cycle(0, 0, '0, '0, 0, "tail");
    expect_cycle(0, 0, '0, '0, 0, "tail");
    chk("cpu acks outstanding", 32'(cpu_q.size()), 32'd0);
    chk("dma acks outstanding", 32'(dma_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
